car_dynamics_ctrl: RTL and testbench
====================================

// Module: car_dynamics_ctrl
// PURPOSE
// Per-frame motion/state controller for one drivable car (player or scripted rival). Turns
// key/command inputs and collision flags into position, speed, sprite-pose and status.
// Generalises the player controller: all limits are parameters, adds a respawn-invulnerability
// phase, optional coast decay, and a STOPPED state after the finish line.
// Sits between the key/AI source and the object drawer; the drawer reads pos_x/pos_y/pose_id.
// PARAMETERS
// COORD_W     11   coordinate width (pixels)
// SPEED_W     10   speed width
// MAX_SPEED   512  speed ceiling
// ACCEL       3    speed gain per frame while accel_req
// BRAKE       10   speed loss per frame while braking or finishing
// DECAY       0    speed loss per frame with no pedal; 0 = disabled
// STEER_STEP  2    x step per frame
// MIN_X/MAX_X 166/414  road edges; car occupies [pos_x, pos_x+CAR_W)
// CAR_W       64   car width
// START_X/START_Y 272/380  spawn position
// SPIN_POSES  12   crash-animation poses (pose_id 1..SPIN_POSES)
// FRAMES_PER_POSE 8    frames each crash pose is held
// RESPAWN_FRAMES  64   invulnerable frames after respawn
// PORTS
// clk          in   1        clock
// resetN       in   1        asynchronous, active-low reset
// frame_start  in   1        one-clk pulse per video frame; all updates happen on it
// accel_req    in   1        accelerate
// brake_req    in   1        brake
// right_req    in   1        steer right
// left_req     in   1        steer left
// car_hit      in   1        collision with another car (sampled on frame_start)
// finish_hit   in   1        finish line reached (sampled on frame_start)
// pos_x        out  COORD_W  car left edge
// pos_y        out  COORD_W  car top edge
// speed        out  SPEED_W  current speed
// pose_id      out  4        0 = upright, 1..SPIN_POSES = crash pose
// visible      out  1        drawer enable (blinks during RESPAWN)
// car_state    out  3        car_state_e
// crash_pulse  out  1        one-clk pulse when CRASH is entered
// BEHAVIOUR
// - Reset: pos_x=START_X, pos_y=START_Y, speed=0, pose_id=0, visible=1, state=DRIVE,
//   crash_pulse=0, last_dir=LEFT, counters=0. Reset mid-animation aborts it immediately.
// - All outputs registered; update in the clk after the one where frame_start=1. Between
//   frame_start pulses every output holds its value (crash_pulse is 0).
// - DRIVE, priority per frame: car_hit -> CRASH; else finish_hit -> FINISH; else normal:
//   speed: brake_req wins over accel_req (brake: max(speed-BRAKE,0)); accel: min(speed+ACCEL,
//   MAX_SPEED); neither: max(speed-DECAY,0). Saturating, never wraps.
//   steer: right_req&&!left_req: if pos_x+CAR_W+STEER_STEP<=MAX_X then pos_x+=STEER_STEP,
//   else CRASH. left_req&&!right_req: if pos_x>=MIN_X+STEER_STEP then pos_x-=STEER_STEP,
//   else CRASH. Both or neither: no move. last_dir latches on each single-key steer.
// - CRASH: entry sets speed=0, pose_id=1, crash_pulse=1, frame counter=0. Each frame pos_x
//   drifts 1 px in last_dir, clamped to [MIN_X, MAX_X-CAR_W]; pose_id advances every
//   FRAMES_PER_POSE frames. After SPIN_POSES*FRAMES_PER_POSE frames -> RESPAWN.
//   Inputs, car_hit, finish_hit ignored in CRASH.
// - RESPAWN: entry sets pos_x=START_X, pose_id=0. visible toggles every 4 frames;
//   car_hit ignored; speed/steer as DRIVE. After RESPAWN_FRAMES frames -> DRIVE, visible=1.
//   finish_hit in RESPAWN -> FINISH (visible forced 1).
// - FINISH: keys ignored; speed -= BRAKE per frame (floor 0); speed==0 -> STOPPED.
// - STOPPED: terminal until reset; all outputs frozen.
// STRUCTURE
// - Package road_fighter_pkg: car_state_e {DRIVE, CRASH, RESPAWN, FINISH, STOPPED},
//   dir_e {LEFT=-1, RIGHT=1}, POSE_UPRIGHT=0.
// - Sub-module sat_speed_step (combinational saturating +/- with ceiling) shared with rival AI.
// - Main FSM, counters and position datapath in this module.
// TESTING
// - Reset, 200 frames accel_req=1 -> speed 3,6,... reaches 512 at frame 171, then holds 512.
// - speed=512, accel_req=brake_req=1 for 3 frames -> speed 502,492,482; pos unchanged.
// - pos_x=348, right_req held -> pos_x=350 next frame; following frame crashes (350+64+2>414):
//   crash_pulse 1 clk, speed=0, pose_id 1..12 each held 8 frames, x drifts +1/frame clamped 350.
// - car_hit on frame 1 of RESPAWN -> ignored; visible 1,1,1,1,0,0,0,0,...; DRIVE after 64 frames.
// - speed=25, finish_hit -> FINISH, speed 15,5,0 -> STOPPED; keys no effect after.
// - resetN low mid-CRASH (pose_id=5) -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/road_fighter_pkg.sv
// Shared types and constants for the road-fighter car controllers (player and rival AI).
package road_fighter_pkg;

  typedef enum logic [2:0] {
    DRIVE   = 3'd0,
    CRASH   = 3'd1,
    RESPAWN = 3'd2,
    FINISH  = 3'd3,
    STOPPED = 3'd4
  } car_state_e;

  typedef enum logic signed [1:0] {
    LEFT  = -2'sd1,
    RIGHT = 2'sd1
  } dir_e;

  localparam logic [3:0] POSE_UPRIGHT = 4'd0;

  // Blink half-period during respawn is 2**VIS_BIT frames.
  localparam int VIS_BIT = 2;

endpackage

// File: rtl/sat_speed_step.sv
// Combinational saturating speed step: add with ceiling, or subtract with floor at zero.
module sat_speed_step #(
  parameter int W    = 10,
  parameter int CEIL = 512
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] step,
  input  logic         sub,
  output logic [W-1:0] result
);

  localparam logic [W:0] CEIL_EXT = (W+1)'(CEIL);

  logic [W:0] sum;

  always_comb begin
    // NOTE: every combinational output gets a value on every path first, so no latch is inferred.
    sum    = {1'b0, value} + {1'b0, step};
    result = value;
    if (sub) begin
      result = (value >= step) ? (value - step) : '0;
    end else if (sum > CEIL_EXT) begin
      result = W'(CEIL);
    end else begin
      result = sum[W-1:0];
    end
  end

endmodule

// File: rtl/car_dynamics_ctrl.sv
// Per-frame motion/state controller for one car: speed, steering, crash spin, respawn blink
// and finish-line stop. All outputs change only on the clock after a frame_start pulse.
module car_dynamics_ctrl
  import road_fighter_pkg::*;
#(
  parameter int COORD_W         = 11,
  parameter int SPEED_W         = 10,
  parameter int MAX_SPEED       = 512,
  parameter int ACCEL           = 3,
  parameter int BRAKE           = 10,
  parameter int DECAY           = 0,
  parameter int STEER_STEP      = 2,
  parameter int MIN_X           = 166,
  parameter int MAX_X           = 414,
  parameter int CAR_W           = 64,
  parameter int START_X         = 272,
  parameter int START_Y         = 380,
  parameter int SPIN_POSES      = 12,
  parameter int FRAMES_PER_POSE = 8,
  parameter int RESPAWN_FRAMES  = 64
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               frame_start,
  input  logic               accel_req,
  input  logic               brake_req,
  input  logic               right_req,
  input  logic               left_req,
  input  logic               car_hit,
  input  logic               finish_hit,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [SPEED_W-1:0] speed,
  output logic [3:0]         pose_id,
  output logic               visible,
  output logic [2:0]         car_state,
  output logic               crash_pulse
);

  localparam int HOLD_W = (FRAMES_PER_POSE > 1) ? $clog2(FRAMES_PER_POSE) : 1;
  localparam int RESP_W = $clog2(RESPAWN_FRAMES + 1);

  localparam logic [COORD_W-1:0] START_X_C   = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_Y_C   = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] STEER_C     = COORD_W'(STEER_STEP);
  localparam logic [COORD_W-1:0] ONE_X       = COORD_W'(1);
  localparam logic [COORD_W-1:0] MIN_X_C     = COORD_W'(MIN_X);
  localparam logic [COORD_W-1:0] DRIFT_MAX   = COORD_W'(MAX_X - CAR_W);
  // Furthest left edge that still lets the car step right without touching the road edge.
  localparam logic [COORD_W-1:0] RIGHT_LIMIT = COORD_W'(MAX_X - CAR_W - STEER_STEP);
  localparam logic [COORD_W-1:0] LEFT_LIMIT  = COORD_W'(MIN_X + STEER_STEP);
  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(FRAMES_PER_POSE - 1);
  localparam logic [3:0]         POSE_LAST   = 4'(SPIN_POSES);
  localparam logic [RESP_W-1:0]  RESP_LAST   = RESP_W'(RESPAWN_FRAMES);

  car_state_e          state;
  dir_e                last_dir;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [RESP_W-1:0]   resp_cnt;
  logic [RESP_W-1:0]   resp_next;

  logic [SPEED_W-1:0]  speed_step;
  logic                speed_sub;
  logic [SPEED_W-1:0]  speed_next;
  logic                steer_r;
  logic                steer_l;
  logic                steer_crash;
  logic                hit_now;
  logic                crash_now;
  logic [COORD_W-1:0]  drift_x;

  assign car_state = state;

  // Finishing always brakes, whatever the pedals say.
  always_comb begin
    speed_step = SPEED_W'(DECAY);
    speed_sub  = 1'b1;
    if (brake_req || finish_hit || state == FINISH) begin
      speed_step = SPEED_W'(BRAKE);
    end else if (accel_req) begin
      speed_step = SPEED_W'(ACCEL);
      speed_sub  = 1'b0;
    end
  end

  sat_speed_step #(
    .W    (SPEED_W),
    .CEIL (MAX_SPEED)
  ) u_speed_step (
    .value  (speed),
    .step   (speed_step),
    .sub    (speed_sub),
    .result (speed_next)
  );

  assign steer_r     = right_req && !left_req;
  assign steer_l     = left_req && !right_req;
  assign steer_crash = (steer_r && (pos_x > RIGHT_LIMIT)) || (steer_l && (pos_x < LEFT_LIMIT));
  assign hit_now     = (state == DRIVE) && car_hit;
  assign crash_now   = hit_now || (!finish_hit && steer_crash);
  assign resp_next   = resp_cnt + RESP_W'(1);

  // Post-crash drift toward the last steering direction, clamped to the road.
  always_comb begin
    drift_x = pos_x;
    if (last_dir == RIGHT) begin
      drift_x = (pos_x < DRIFT_MAX) ? pos_x + ONE_X : DRIFT_MAX;
    end else begin
      drift_x = (pos_x > MIN_X_C) ? pos_x - ONE_X : MIN_X_C;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pos_x       <= START_X_C;
      pos_y       <= START_Y_C;
      speed       <= '0;
      pose_id     <= POSE_UPRIGHT;
      visible     <= 1'b1;
      state       <= DRIVE;
      crash_pulse <= 1'b0;
      last_dir    <= LEFT;
      hold_cnt    <= '0;
      resp_cnt    <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      crash_pulse <= 1'b0;
      if (frame_start) begin
        unique case (state)
          DRIVE, RESPAWN: begin
            if (!hit_now && !finish_hit) begin
              if (steer_r) last_dir <= RIGHT;
              else if (steer_l) last_dir <= LEFT;
            end
            if (crash_now) begin
              state       <= CRASH;
              speed       <= '0;
              pose_id     <= 4'd1;
              crash_pulse <= 1'b1;
              hold_cnt    <= '0;
              visible     <= 1'b1;
            end else if (finish_hit) begin
              state   <= FINISH;
              speed   <= speed_next;
              visible <= 1'b1;
            end else begin
              speed <= speed_next;
              if (steer_r) pos_x <= pos_x + STEER_C;
              else if (steer_l) pos_x <= pos_x - STEER_C;
              if (state == RESPAWN) begin
                if (resp_next == RESP_LAST) begin
                  state   <= DRIVE;
                  visible <= 1'b1;
                end else begin
                  resp_cnt <= resp_next;
                  visible  <= ~resp_next[VIS_BIT];
                end
              end
            end
          end

          CRASH: begin
            if (hold_cnt == HOLD_LAST && pose_id == POSE_LAST) begin
              state    <= RESPAWN;
              pos_x    <= START_X_C;
              pose_id  <= POSE_UPRIGHT;
              resp_cnt <= '0;
              visible  <= 1'b1;
              hold_cnt <= '0;
            end else begin
              pos_x <= drift_x;
              if (hold_cnt == HOLD_LAST) begin
                hold_cnt <= '0;
                pose_id  <= pose_id + 4'd1;
              end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end
            end
          end

          FINISH: begin
            speed <= speed_next;
            if (speed_next == '0) state <= STOPPED;
          end

          STOPPED: ;

          default: state <= DRIVE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_car_dynamics_ctrl.sv
// Directed bench for car_dynamics_ctrl: acceleration ramp, brake priority, wall crash and spin,
// respawn blink, finish stop, async reset mid-crash and left-edge crash.
module tb_car_dynamics_ctrl;
  import road_fighter_pkg::*;

  logic        clk = 1'b0;
  logic        resetN;
  logic        frame_start;
  logic        accel_req, brake_req, right_req, left_req, car_hit, finish_hit;
  logic [10:0] pos_x, pos_y;
  logic [9:0]  speed;
  logic [3:0]  pose_id;
  logic        visible;
  logic [2:0]  car_state;
  logic        crash_pulse;

  int tests = 0;
  int fails = 0;

  car_dynamics_ctrl dut (
    .clk         (clk),
    .resetN      (resetN),
    .frame_start (frame_start),
    .accel_req   (accel_req),
    .brake_req   (brake_req),
    .right_req   (right_req),
    .left_req    (left_req),
    .car_hit     (car_hit),
    .finish_hit  (finish_hit),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .speed       (speed),
    .pose_id     (pose_id),
    .visible     (visible),
    .car_state   (car_state),
    .crash_pulse (crash_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One frame: pulse frame_start for one clock, return on the following falling edge.
  task automatic do_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pos_x"}, pos_x, 272);
    check({tag, "_pos_y"}, pos_y, 380);
    check({tag, "_speed"}, speed, 0);
    check({tag, "_pose"}, pose_id, 0);
    check({tag, "_visible"}, visible, 1);
    check({tag, "_state"}, car_state, DRIVE);
    check({tag, "_pulse"}, crash_pulse, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; frame_start = 1'b0;
    accel_req = 1'b0; brake_req = 1'b0; right_req = 1'b0; left_req = 1'b0;
    car_hit = 1'b0; finish_hit = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    resetN = 1'b1;

    // Acceleration ramp: min(3*f, 512).
    accel_req = 1'b1;
    for (int f = 1; f <= 200; f++) begin
      do_frame();
      if (f <= 2 || f == 170 || f == 171 || f == 200)
        check($sformatf("accel_f%0d", f), speed, (f * 3 > 512) ? 512 : f * 3);
    end
    check("accel_pos_x", pos_x, 272);
    accel_req = 1'b0;

    // No frame_start: everything holds.
    repeat (3) @(negedge clk);
    check("idle_hold_speed", speed, 512);
    check("idle_pulse", crash_pulse, 0);

    // Brake wins over accel.
    accel_req = 1'b1; brake_req = 1'b1;
    do_frame(); check("brake_1", speed, 502);
    do_frame(); check("brake_2", speed, 492);
    do_frame(); check("brake_3", speed, 482);
    check("brake_pos_x", pos_x, 272);
    accel_req = 1'b0; brake_req = 1'b0;

    // Steer right to the wall and crash.
    right_req = 1'b1;
    repeat (38) do_frame();
    check("steer_348", pos_x, 348);
    check("coast_speed", speed, 482);
    do_frame();
    check("steer_350", pos_x, 350);
    check("steer_state", car_state, DRIVE);
    do_frame();
    check("wall_crash_state", car_state, CRASH);
    check("wall_crash_speed", speed, 0);
    check("wall_crash_pose", pose_id, 1);
    check("wall_crash_pulse", crash_pulse, 1);
    check("wall_crash_x", pos_x, 350);
    @(negedge clk);
    check("pulse_one_clk", crash_pulse, 0);
    right_req = 1'b0;

    for (int k = 1; k <= 95; k++) begin
      do_frame();
      if (k % 8 == 0 || k % 8 == 7)
        check($sformatf("spin_pose_k%0d", k), pose_id, 1 + k / 8);
      if (k == 1 || k == 95) check($sformatf("spin_x_k%0d", k), pos_x, 350);
    end
    check("spin_state", car_state, CRASH);
    do_frame();
    check("respawn_state", car_state, RESPAWN);
    check("respawn_x", pos_x, 272);
    check("respawn_pose", pose_id, 0);
    check("respawn_vis0", visible, 1);

    // car_hit on first respawn frame is ignored; blink every 4 frames.
    car_hit = 1'b1;
    do_frame();
    check("respawn_hit_state", car_state, RESPAWN);
    check("respawn_vis1", visible, 1);
    car_hit = 1'b0;
    for (int n = 2; n <= 64; n++) begin
      do_frame();
      if (n <= 9 || n >= 62)
        check($sformatf("respawn_vis%0d", n), visible, (n == 64) ? 1 : (((n / 4) % 2) == 0));
      if (n == 63) check("respawn_state63", car_state, RESPAWN);
    end
    check("respawn_done", car_state, DRIVE);

    // Finish from speed 25: 15, 5, 0 -> STOPPED.
    accel_req = 1'b1;
    repeat (15) do_frame();
    check("pre_finish_45", speed, 45);
    accel_req = 1'b0; brake_req = 1'b1;
    repeat (2) do_frame();
    check("pre_finish_25", speed, 25);
    brake_req = 1'b0;
    finish_hit = 1'b1;
    do_frame();
    check("finish_state", car_state, FINISH);
    check("finish_15", speed, 15);
    finish_hit = 1'b0; accel_req = 1'b1;
    do_frame();
    check("finish_5", speed, 5);
    check("finish_state2", car_state, FINISH);
    do_frame();
    check("finish_0", speed, 0);
    check("stopped_state", car_state, STOPPED);
    right_req = 1'b1; car_hit = 1'b1;
    repeat (3) do_frame();
    check("stopped_hold_state", car_state, STOPPED);
    check("stopped_hold_speed", speed, 0);
    check("stopped_hold_x", pos_x, 272);
    check("stopped_hold_pulse", crash_pulse, 0);
    accel_req = 1'b0; right_req = 1'b0;

    // Reset, car_hit crash drifting left, async reset at pose 5.
    @(negedge clk); resetN = 1'b0;
    @(negedge clk); resetN = 1'b1;
    do_frame();
    check("hit_crash_state", car_state, CRASH);
    check("hit_crash_pulse", crash_pulse, 1);
    car_hit = 1'b0;
    repeat (33) do_frame();
    check("mid_crash_pose", pose_id, 5);
    check("mid_crash_x", pos_x, 239);
    #2;
    resetN = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    resetN = 1'b1;

    // Left edge: 166 is the last legal position, next left step crashes.
    left_req = 1'b1;
    repeat (53) do_frame();
    check("left_166", pos_x, 166);
    check("left_state", car_state, DRIVE);
    do_frame();
    check("left_crash_state", car_state, CRASH);
    check("left_crash_pulse", crash_pulse, 1);
    left_req = 1'b0;
    do_frame();
    check("left_drift_clamp", pos_x, 166);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
